// File: rtl/uart_pkg.sv
// Shared types and limits for the UART transmit path.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register in front of the UART shifter; accept to hold_full in one edge.
// tx_ready is the registered inverse of hold_full, so the source stalls while a word waits.
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 div_clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 pop,
  output logic                 hold_full,
  output logic [DATA_BITS-1:0] hold_data
);

  if (DATA_BITS < 1 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_width
    $error("uart_tx_hold: DATA_BITS out of range");
  end

  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  // pop only happens while full and accept only while empty, so they never collide
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (tx_valid && !full_q) begin
      full_d = 1'b1;
      data_d = tx_data;
    end
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign hold_full = full_q;
  assign hold_data = data_q;
  assign tx_ready  = ~full_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART framer: start, DATA_BITS data, optional parity, 1-2 stop bits; one div_clk per bit.
// Start bit appears one edge after accept; frames run back-to-back while the hold buffer refills.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int LSB_FIRST   = 1
) (
  input  logic                 div_clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 brk,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 frame_done
);

  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE != int'(PAR_NONE) && PARITY_MODE != int'(PAR_EVEN) &&
      PARITY_MODE != int'(PAR_ODD)) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int              CW        = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]   LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0]   LAST_STOP = CW'(STOP_BITS - 1);
  localparam bit              HAS_PAR   = (PARITY_MODE != int'(PAR_NONE));
  localparam bit              ODD_PAR   = (PARITY_MODE == int'(PAR_ODD));

  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic                 pop;

  uart_tx_hold #(
    .DATA_BITS(DATA_BITS)
  ) u_hold (
    .div_clk   (div_clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .pop       (pop),
    .hold_full (hold_full),
    .hold_data (hold_data)
  );

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;

  logic last_stop;
  logic load_ok;
  logic out_bit;

  assign last_stop = (state_q == STOP) && (cnt_q == LAST_STOP);
  // In IDLE a low line means a break was just released: give it one high cycle first
  assign load_ok   = hold_full && !brk &&
                     (((state_q == IDLE) && serial_q) || last_stop);
  assign out_bit   = (LSB_FIRST != 0) ? shift_q[0] : shift_q[DATA_BITS-1];

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_ok) begin
          state_d = START;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_DATA) begin
          state_d = HAS_PAR ? PARITY : STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        state_d = STOP;
        cnt_d   = '0;
      end
      STOP: begin
        if (cnt_q == LAST_STOP) begin
          state_d = load_ok ? START : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // tx_serial is registered, so it is computed from the state being entered
  always_comb begin
    pop      = load_ok;
    shift_d  = shift_q;
    par_d    = par_q;
    serial_d = 1'b1;
    if (load_ok) begin
      shift_d = hold_data;
      par_d   = ODD_PAR ? ~(^hold_data) : ^hold_data;
    end else if (state_d == DATA) begin
      shift_d = (LSB_FIRST != 0) ? {1'b0, shift_q[DATA_BITS-1:1]}
                                 : {shift_q[DATA_BITS-2:0], 1'b0};
    end
    case (state_d)
      IDLE:    serial_d = ~brk;
      START:   serial_d = 1'b0;
      DATA:    serial_d = out_bit;
      PARITY:  serial_d = par_q;
      STOP:    serial_d = 1'b1;
      default: serial_d = 1'b1;
    endcase
  end

  assign tx_serial  = serial_q;
  assign tx_busy    = (state_q != IDLE);
  assign frame_done = last_stop;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Four framer configurations driven by directed and random traffic, checked against a frame-queue model.
module tb_uart_tx_frame;

  logic       div_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [8:0] dat   [4];
  logic       vld   [4];
  logic       brk_i [4];
  logic       ser   [4];
  logic       rdy   [4];
  logic       bsy   [4];
  logic       dn    [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 div_clk = ~div_clk;

  // 0: 8E1 LSB, 1: 8O1 LSB, 2: 7N2 MSB, 3: 8N1 LSB
  int db_c  [4] = '{8, 8, 7, 8};
  int pm_c  [4] = '{1, 2, 0, 0};
  int sb_c  [4] = '{1, 1, 2, 1};
  int lsb_c [4] = '{1, 1, 0, 1};

  uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .LSB_FIRST(1)) u_even (
    .div_clk(div_clk), .rst_n(rst_n), .tx_data(dat[0][7:0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .brk(brk_i[0]), .tx_serial(ser[0]), .tx_busy(bsy[0]),
    .frame_done(dn[0]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .LSB_FIRST(1)) u_odd (
    .div_clk(div_clk), .rst_n(rst_n), .tx_data(dat[1][7:0]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .brk(brk_i[1]), .tx_serial(ser[1]), .tx_busy(bsy[1]),
    .frame_done(dn[1]));
  uart_tx_frame #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .LSB_FIRST(0)) u_7n2 (
    .div_clk(div_clk), .rst_n(rst_n), .tx_data(dat[2][6:0]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .brk(brk_i[2]), .tx_serial(ser[2]), .tx_busy(bsy[2]),
    .frame_done(dn[2]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .LSB_FIRST(1)) u_8n1 (
    .div_clk(div_clk), .rst_n(rst_n), .tx_data(dat[3][7:0]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .brk(brk_i[3]), .tx_serial(ser[3]), .tx_busy(bsy[3]),
    .frame_done(dn[3]));

  // Reference model: a queue of line levels still to be emitted for the current frame
  bit         mq     [4][$];
  bit         m_held [4];
  logic [8:0] m_word [4];
  bit         m_busy [4];
  bit         m_line [4];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      m_held[k] = 1'b0;
      m_word[k] = '0;
      m_busy[k] = 1'b0;
      m_line[k] = 1'b1;
    end
  endtask

  task automatic build_frame(input int k, input logic [8:0] w);
    int ones;
    int idx;
    ones = 0;
    mq[k].push_back(1'b0);
    for (int i = 0; i < db_c[k]; i++) begin
      idx = (lsb_c[k] != 0) ? i : db_c[k] - 1 - i;
      mq[k].push_back(w[idx]);
      ones += int'(w[idx]);
    end
    if (pm_c[k] == 1) mq[k].push_back(ones % 2 == 1);
    if (pm_c[k] == 2) mq[k].push_back(ones % 2 == 0);
    for (int i = 0; i < sb_c[k]; i++) mq[k].push_back(1'b1);
  endtask

  task automatic model_edge(input int k, input bit v, input logic [8:0] w, input bit b);
    bit boundary;
    bit accept;
    boundary = !m_busy[k] || (mq[k].size() == 0);
    accept   = v && !m_held[k];
    if (boundary && m_held[k] && !b && (m_busy[k] || m_line[k])) begin
      build_frame(k, m_word[k]);
      m_held[k] = 1'b0;
    end
    if (mq[k].size() > 0) begin
      m_line[k] = mq[k].pop_front();
      m_busy[k] = 1'b1;
    end else begin
      m_busy[k] = 1'b0;
      m_line[k] = !b;
    end
    if (accept) begin
      m_held[k] = 1'b1;
      m_word[k] = w & 9'((1 << db_c[k]) - 1);
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("model_serial%0d", k), int'(ser[k]), int'(m_line[k]));
      check($sformatf("model_busy%0d", k), int'(bsy[k]), int'(m_busy[k]));
      check($sformatf("model_done%0d", k), int'(dn[k]),
            int'(m_busy[k] && mq[k].size() == 0));
      check($sformatf("model_ready%0d", k), int'(rdy[k]), int'(!m_held[k]));
    end
  endtask

  task automatic tick();
    @(posedge div_clk);
    for (int k = 0; k < 4; k++) model_edge(k, vld[k], dat[k], brk_i[k]);
    @(negedge div_clk);
    compare_model();
  endtask

  int a5_seq [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  int c41_seq[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1};
  int bb_seq [20] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1,
                      0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
  int busy_cnt;

  initial begin
    for (int k = 0; k < 4; k++) begin
      dat[k] = '0; vld[k] = 1'b0; brk_i[k] = 1'b0;
    end
    model_reset();
    repeat (2) @(negedge div_clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_serial%0d", k), int'(ser[k]), 1);
      check($sformatf("rst_ready%0d", k), int'(rdy[k]), 1);
      check($sformatf("rst_busy%0d", k), int'(bsy[k]), 0);
      check($sformatf("rst_done%0d", k), int'(dn[k]), 0);
    end
    rst_n = 1'b1;
    tick();

    // 0xA5, 8E1
    vld[0] = 1'b1; dat[0] = 9'h0A5;
    tick();
    vld[0] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      check("a5_serial", int'(ser[0]), a5_seq[i]);
      check("a5_busy", int'(bsy[0]), 1);
      check("a5_done", int'(dn[0]), int'(i == 10));
    end
    tick();
    check("a5_idle_busy", int'(bsy[0]), 0);
    check("a5_idle_serial", int'(ser[0]), 1);

    // 0x07 with even and odd parity side by side
    vld[0] = 1'b1; dat[0] = 9'h007;
    vld[1] = 1'b1; dat[1] = 9'h007;
    tick();
    vld[0] = 1'b0; vld[1] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 9) begin
        check("even_par_07", int'(ser[0]), 1);
        check("odd_par_07", int'(ser[1]), 0);
      end
    end
    tick();

    // 0x41, 7N2 MSB first
    vld[2] = 1'b1; dat[2] = 9'h041;
    tick();
    vld[2] = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i < 10) check("c41_serial", int'(ser[2]), c41_seq[i]);
      busy_cnt += int'(bsy[2]);
    end
    check("c41_busy_cycles", busy_cnt, 10);

    // back-to-back 0x55, 0x0F on 8N1 with tx_valid held
    vld[3] = 1'b1; dat[3] = 9'h055;
    tick();
    dat[3] = 9'h00F;
    busy_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i == 0) check("b2b_ready_after_load", int'(rdy[3]), 1);
      if (i == 1) vld[3] = 1'b0;
      if (i < 20) check("b2b_serial", int'(ser[3]), bb_seq[i]);
      if (i >= 1 && i <= 9) check("b2b_ready_low", int'(rdy[3]), 0);
      busy_cnt += int'(bsy[3]);
    end
    check("b2b_busy_cycles", busy_cnt, 20);

    // break raised mid-frame, word queued under break, then released
    vld[3] = 1'b1; dat[3] = 9'h033;
    tick();
    vld[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) brk_i[3] = 1'b1;
      check("brk_frame_busy", int'(bsy[3]), 1);
    end
    tick();
    check("brk_line_low", int'(ser[3]), 0);
    check("brk_not_busy", int'(bsy[3]), 0);
    vld[3] = 1'b1; dat[3] = 9'h096;
    tick();
    vld[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("brk_hold_serial", int'(ser[3]), 0);
      check("brk_hold_busy", int'(bsy[3]), 0);
      check("brk_hold_ready", int'(rdy[3]), 0);
    end
    brk_i[3] = 1'b0;
    tick();
    check("brk_release_high", int'(ser[3]), 1);
    check("brk_release_idle", int'(bsy[3]), 0);
    tick();
    check("brk_start_bit", int'(ser[3]), 0);
    check("brk_start_busy", int'(bsy[3]), 1);
    repeat (11) tick();

    // reset mid-frame with a second word held
    vld[0] = 1'b1; dat[0] = 9'h03C;
    tick();
    dat[0] = 9'h0C3;
    tick();
    tick();
    vld[0] = 1'b0;
    repeat (4) tick();
    check("pre_rst_busy", int'(bsy[0]), 1);
    check("pre_rst_ready", int'(rdy[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_serial", int'(ser[0]), 1);
    check("async_rst_ready", int'(rdy[0]), 1);
    check("async_rst_busy", int'(bsy[0]), 0);
    model_reset();
    @(posedge div_clk);
    @(negedge div_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("post_rst_serial", int'(ser[0]), 1);
      check("post_rst_busy", int'(bsy[0]), 0);
    end

    // random traffic on all four configurations
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        vld[k] = ($urandom_range(0, 2) != 0);
        dat[k] = 9'($urandom);
        if ($urandom_range(0, 59) == 0) brk_i[k] = ~brk_i[k];
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0; brk_i[k] = 1'b0;
    end
    repeat (30) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
